// File: rtl/capture_sequencer.sv
// capture_sequencer: sequences the mic ring buffers through
// prime -> armed -> post-trigger capture -> correlator run -> holdoff.
// Optional correlator timeout is enabled by defining CAPTURE_SEQ_TIMEOUT_EN;
// without it WAIT blocks until corr_done and timeout_err stays 0.
module capture_sequencer #(
    parameter int unsigned NUM_MICS      = 4,
    parameter int unsigned PRIME_SAMPLES = 512,
    parameter int unsigned POST_SAMPLES  = 256,
    parameter int unsigned HOLDOFF_CYC   = 1_000_000,
    parameter int unsigned TIMEOUT_CYC   = 65_536
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        sample_rdy,
    input  logic [NUM_MICS-1:0]         noise_detected,
    input  logic                        corr_done,
    output logic                        capture_en,
    output logic [$clog2(NUM_MICS)-1:0] trig_mic,
    output logic                        corr_start,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int unsigned IDX_W   = $clog2(NUM_MICS);
    localparam int unsigned SMP_MAX = (PRIME_SAMPLES > POST_SAMPLES) ? PRIME_SAMPLES : POST_SAMPLES;
    localparam int unsigned CYC_MAX = (HOLDOFF_CYC > TIMEOUT_CYC) ? HOLDOFF_CYC : TIMEOUT_CYC;
    localparam int unsigned SMP_W   = $clog2(SMP_MAX + 1);
    localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);

    localparam logic [SMP_W-1:0] PRIME_LAST = SMP_W'(PRIME_SAMPLES - 1);
    localparam logic [SMP_W-1:0] POST_LAST  = SMP_W'(POST_SAMPLES - 1);
    localparam logic [SMP_W-1:0] SMP_SAT    = SMP_W'(SMP_MAX);
    localparam logic [CYC_W-1:0] HOLD_LAST  = CYC_W'(HOLDOFF_CYC - 1);
    localparam logic [CYC_W-1:0] CYC_SAT    = CYC_W'(CYC_MAX);
`ifdef CAPTURE_SEQ_TIMEOUT_EN
    localparam logic [CYC_W-1:0] TMO_LAST   = CYC_W'(TIMEOUT_CYC - 1);
`endif

    typedef enum logic [2:0] {
        S_PRIME,
        S_ARMED,
        S_POST,
        S_START,
        S_WAIT,
        S_HOLDOFF
    } state_t;

    state_t           state;
    logic [SMP_W-1:0] smp_cnt;
    logic [CYC_W-1:0] cyc_cnt;
    logic [SMP_W-1:0] smp_inc;
    logic [CYC_W-1:0] cyc_inc;
    logic [IDX_W-1:0] first_idx;
    logic             found;

    // Saturating increments and lowest-index priority encode of the noise flags
    always_comb begin
        smp_inc   = (smp_cnt == SMP_SAT) ? smp_cnt : smp_cnt + 1'b1;
        cyc_inc   = (cyc_cnt == CYC_SAT) ? cyc_cnt : cyc_cnt + 1'b1;
        first_idx = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < NUM_MICS; i++) begin
            if (noise_detected[i] && !found) begin
                first_idx = IDX_W'(i);
                found     = 1'b1;
            end
        end
    end

    // Sequencer FSM; every transition clears both counters so a sample
    // arriving on an exit cycle is not carried into the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_PRIME;
            smp_cnt     <= '0;
            cyc_cnt     <= '0;
            capture_en  <= 1'b0;
            trig_mic    <= '0;
            corr_start  <= 1'b0;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            corr_start  <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_PRIME: begin
                    capture_en <= 1'b1;
                    busy       <= 1'b1;
                    if (sample_rdy) begin
                        if (smp_cnt == PRIME_LAST) begin
                            state   <= S_ARMED;
                            busy    <= 1'b0;
                            smp_cnt <= '0;
                            cyc_cnt <= '0;
                        end else begin
                            smp_cnt <= smp_inc;
                        end
                    end
                end
                S_ARMED: begin
                    if (|noise_detected) begin
                        state    <= S_POST;
                        busy     <= 1'b1;
                        trig_mic <= first_idx;
                        smp_cnt  <= '0;
                        cyc_cnt  <= '0;
                    end
                end
                S_POST: begin
                    if (sample_rdy) begin
                        if (smp_cnt == POST_LAST) begin
                            state      <= S_START;
                            capture_en <= 1'b0;
                            corr_start <= 1'b1;
                            smp_cnt    <= '0;
                            cyc_cnt    <= '0;
                        end else begin
                            smp_cnt <= smp_inc;
                        end
                    end
                end
                S_START: begin
                    state   <= S_WAIT;
                    smp_cnt <= '0;
                    cyc_cnt <= '0;
                end
                S_WAIT: begin
                    if (corr_done) begin
                        state   <= S_HOLDOFF;
                        smp_cnt <= '0;
                        cyc_cnt <= '0;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
                    end else if (cyc_cnt == TMO_LAST) begin
                        state       <= S_HOLDOFF;
                        timeout_err <= 1'b1;
                        smp_cnt     <= '0;
                        cyc_cnt     <= '0;
                    end else begin
                        cyc_cnt <= cyc_inc;
`endif
                    end
                end
                S_HOLDOFF: begin
                    if (cyc_cnt == HOLD_LAST) begin
                        state      <= S_PRIME;
                        capture_en <= 1'b1;
                        smp_cnt    <= '0;
                        cyc_cnt    <= '0;
                    end else begin
                        cyc_cnt <= cyc_inc;
                    end
                end
                default: begin
                    state   <= S_PRIME;
                    smp_cnt <= '0;
                    cyc_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 SHALL have parameter NUM_MICS, default 4: number of microphone buffers sequenced.
REQ-002 SHALL have parameter PRIME_SAMPLES, default 512: samples required to refill buffers before arming.
REQ-003 SHALL have parameter POST_SAMPLES, default 256: samples captured after trigger.
REQ-004 SHALL have parameter HOLDOFF_CYC, default 1_000_000: clock cycles idle after a capture completes.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 65_536: maximum clock cycles to wait for the correlator.
REQ-006 SHALL have port clock  input  1  single system clock, rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port sample_rdy  input  1  common ADC sample strobe, one cycle per sample.
REQ-009 SHALL have port noise_detected  input  NUM_MICS  per-buffer noise flags, bit i = mic i.
REQ-010 SHALL have port corr_done  input  1  correlator completion pulse.
REQ-011 SHALL have port capture_en  output  1  buffer write enable; the buffers receive data_rdy = sample_rdy AND capture_en.
REQ-012 SHALL have port trig_mic  output  $clog2(NUM_MICS)  index of the first mic to detect noise.
REQ-013 SHALL have port corr_start  output  1  single-cycle correlator start pulse.
REQ-014 SHALL have port busy  output  1  high in every state except ARMED.
REQ-015 SHALL have port timeout_err  output  1  single-cycle pulse on correlator timeout.

Function
REQ-016 SHALL implement the states PRIME, ARMED, POST, START, WAIT and HOLDOFF.
REQ-017 PRIME SHALL count sample_rdy pulses and SHALL move to ARMED on the cycle the PRIME_SAMPLES-th pulse is counted; noise_detected SHALL be ignored during PRIME.
REQ-018 ARMED SHALL move to POST on the first cycle in which noise_detected is nonzero, SHALL latch trig_mic in that cycle as the lowest set index, and SHALL clear the sample counter.
REQ-019 POST SHALL count sample_rdy pulses and SHALL move to START on the cycle the POST_SAMPLES-th pulse is counted; that pulse SHALL still be written to the buffers.
REQ-020 capture_en SHALL be 1 in PRIME, ARMED and POST, and 0 in START, WAIT and HOLDOFF (registered output, updated with the state).
REQ-021 START SHALL assert corr_start for exactly one cycle and SHALL then move to WAIT.
REQ-022 WAIT SHALL move to HOLDOFF on corr_done; corr_done in any other state SHALL be ignored.
REQ-023 HOLDOFF SHALL count HOLDOFF_CYC clock cycles and SHALL then move to PRIME.
REQ-024 trig_mic SHALL hold its latched value until the next trigger.
REQ-025 Each counter SHALL be $clog2(max+1) bits wide, SHALL saturate without wrapping, and SHALL clear on every state entry.
REQ-026 If sample_rdy and a state-exit condition occur in the same cycle, the transition SHALL take priority and the counter SHALL restart at 0 in the new state.

Reset
REQ-027 reset SHALL take priority over all other inputs.
REQ-028 While reset is asserted: state = PRIME, all counters = 0, capture_en = 0, trig_mic = 0, corr_start = 0, busy = 1, timeout_err = 0.
REQ-029 capture_en SHALL be 1 from the first cycle after reset is deasserted.
REQ-030 A reset asserted mid-capture SHALL abandon the capture and SHALL NOT emit corr_start.

Configuration
REQ-031 Macro CAPTURE_SEQ_TIMEOUT_EN SHALL control the correlator timeout.
REQ-032 With CAPTURE_SEQ_TIMEOUT_EN defined, WAIT SHALL count clock cycles; on reaching TIMEOUT_CYC without corr_done it SHALL pulse timeout_err for one cycle and move to HOLDOFF. If corr_done arrives in the timeout cycle, corr_done SHALL win and no error SHALL be flagged.
REQ-033 Without CAPTURE_SEQ_TIMEOUT_EN, WAIT SHALL wait indefinitely and timeout_err SHALL be tied to 0.

Verification
REQ-034 Scenario: reset, then 512 sample_rdy pulses -> ARMED (busy = 0) after the 512th pulse; noise_detected = 4'b1111 injected at pulse 300 is ignored.
REQ-035 Scenario: ARMED, noise_detected = 4'b0110 -> trig_mic = 1; capture_en drops after exactly 256 further sample_rdy pulses; corr_start pulses once, one cycle later.
REQ-036 Scenario: WAIT, corr_done after 10 cycles -> HOLDOFF; PRIME is re-entered after HOLDOFF_CYC cycles (set to 100 in the bench).
REQ-037 Scenario (with CAPTURE_SEQ_TIMEOUT_EN, TIMEOUT_CYC = 50): no corr_done -> timeout_err high for 1 cycle at WAIT+50, then HOLDOFF; without the macro, the block stays in WAIT and timeout_err stays 0.
REQ-038 Scenario: reset asserted at POST sample 100 -> next cycle is PRIME with capture_en = 0, and no corr_start is emitted.
REQ-039 Scenario: corr_done pulsed while in ARMED or POST -> no state change.
